// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive framer. The frame-data state code is
// also compared against by copy_packet_to_mem.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_PREAMBLE = 3'b001,
        ST_DATA     = 3'b011,
        ST_CHECK    = 3'b100,
        ST_DROP     = 3'b101
    } rx_state_e;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;

    // Reflected IEEE 802.3 polynomial, LSB-first shifting.
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected, LSB-first). Shared by the RX
// framer and the TX path.
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ d[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_rx_frame_fsm.sv
// GMII receive framer: strips preamble/SFD, forwards DA..FCS one byte per clock,
// and reports length, FCS and error status with a one-cycle end-of-frame pulse.
module eth_rx_frame_fsm
    import eth_rx_pkg::*;
#(
    parameter int unsigned pDATA_W  = 8,
    parameter int unsigned pLEN_W   = 16,
    parameter int unsigned pPRE_MIN = 1,
    parameter int unsigned pMIN_LEN = 64,
    parameter int unsigned pMAX_LEN = 1518
) (
    input  logic               iclk,
    input  logic               i_rst,
    input  logic               irx_dv,
    input  logic               irx_er,
    input  logic [pDATA_W-1:0] irx_d,
    output logic               odv,
    output logic [pDATA_W-1:0] orx_d,
    output logic [2:0]         oFSM_state,
    output logic               oframe_end,
    output logic               ocrc_ok,
    output logic               oerr,
    output logic [pLEN_W-1:0]  olen
);

    localparam logic [2:0]        PRE_MIN = 3'(pPRE_MIN);
    localparam logic [pLEN_W-1:0] MIN_LEN = pLEN_W'(pMIN_LEN);
    localparam logic [pLEN_W-1:0] MAX_LEN = pLEN_W'(pMAX_LEN);

    rx_state_e         state_q;
    logic              rdv_q;
    logic [2:0]        pre_cnt_q;
    logic [31:0]       crc_q;
    logic [31:0]       crc_next;
    logic [pLEN_W-1:0] len_q;
    logic              rerr_q;
    logic              start;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_q),
        .d       (irx_d[7:0]),
        .crc_out (crc_next)
    );

    // Only a rising edge of RX_DV opens a frame, so a tail seen at reset release is ignored.
    assign start = irx_dv & ~rdv_q;

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            rdv_q      <= 1'b1;
            pre_cnt_q  <= 3'd0;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            rerr_q     <= 1'b0;
            odv        <= 1'b0;
            orx_d      <= '0;
            oFSM_state <= ST_IDLE;
            oframe_end <= 1'b0;
            ocrc_ok    <= 1'b0;
            oerr       <= 1'b0;
            olen       <= '0;
        end else begin
            rdv_q      <= irx_dv;
            odv        <= 1'b0;
            oframe_end <= 1'b0;
            oFSM_state <= state_q;

            unique case (state_q)
                // CHECK also watches for a start so a one-cycle IPG loses no frame.
                ST_IDLE, ST_CHECK: begin
                    if (state_q == ST_CHECK) begin
                        oframe_end <= 1'b1;
                        ocrc_ok    <= (crc_q == CRC_RESIDUE) && (len_q >= MIN_LEN) && !rerr_q;
                        oerr       <= rerr_q || (len_q < MIN_LEN);
                        olen       <= len_q;
                    end
                    state_q <= ST_IDLE;
                    if (start) begin
                        if (irx_d[7:0] == PRE_BYTE) begin
                            state_q   <= ST_PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!irx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (irx_er) begin
                        state_q <= ST_DROP;
                    end else if (irx_d[7:0] == PRE_BYTE) begin
                        if (pre_cnt_q != 3'd7) begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (irx_d[7:0] == SFD_BYTE && pre_cnt_q >= PRE_MIN) begin
                        state_q <= ST_DATA;
                        crc_q   <= CRC_INIT;
                        len_q   <= '0;
                        rerr_q  <= 1'b0;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end

                ST_DATA: begin
                    if (!irx_dv) begin
                        state_q <= ST_CHECK;
                    end else if (len_q == MAX_LEN) begin
                        state_q    <= ST_DROP;
                        oframe_end <= 1'b1;
                        ocrc_ok    <= 1'b0;
                        oerr       <= 1'b1;
                        olen       <= MAX_LEN;
                    end else begin
                        odv   <= 1'b1;
                        orx_d <= irx_d;
                        crc_q <= crc_next;
                        if (len_q != '1) begin
                            len_q <= len_q + 1'b1;
                        end
                        if (irx_er) begin
                            rerr_q <= 1'b1;
                        end
                    end
                end

                ST_DROP: begin
                    if (!irx_dv) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fsm.sv
// Randomized self-checking bench for eth_rx_frame_fsm: frames are built with a
// bench-computed FCS and the expected stream/status comes from frame-level rules.
module tb_eth_rx_frame_fsm;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef struct {
        int len;
        bit ok;
        bit err;
    } end_t;

    logic        iclk = 1'b0;
    logic        i_rst = 1'b0;
    logic        irx_dv = 1'b0;
    logic        irx_er = 1'b0;
    logic [7:0]  irx_d = 8'h00;
    logic        odv;
    logic [7:0]  orx_d;
    logic [2:0]  oFSM_state;
    logic        oframe_end;
    logic        ocrc_ok;
    logic        oerr;
    logic [15:0] olen;

    int vectors = 0;
    int miscompares = 0;

    byte unsigned frm[$];
    byte unsigned exp_q[$];
    byte unsigned got[$];
    end_t         ends[$];
    end_t         exp_e[$];
    bit           overlap_seen = 0;
    bit           state_bad = 0;

    eth_rx_frame_fsm dut (
        .iclk       (iclk),
        .i_rst      (i_rst),
        .irx_dv     (irx_dv),
        .irx_er     (irx_er),
        .irx_d      (irx_d),
        .odv        (odv),
        .orx_d      (orx_d),
        .oFSM_state (oFSM_state),
        .oframe_end (oframe_end),
        .ocrc_ok    (ocrc_ok),
        .oerr       (oerr),
        .olen       (olen)
    );

    always #5 iclk = ~iclk;

    // Monitor away from the active edge.
    always @(negedge iclk) begin
        if (i_rst) begin
            if (odv) begin
                got.push_back(orx_d);
                if (oFSM_state !== 3'b011) state_bad = 1;
            end
            if (oframe_end) begin
                end_t e;
                e.len = int'(olen);
                e.ok  = ocrc_ok;
                e.err = oerr;
                ends.push_back(e);
                if (odv) overlap_seen = 1;
            end
        end
    end

    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ frm[i][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else                            c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic bit fcs_good();
        int n = frm.size();
        return {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == crc_of(n - 4);
    endfunction

    // Frame-level outcome: truncated length, error if rx_er/runt/overlong, ok otherwise iff FCS good.
    function automatic end_t model_end(input int n, input bit er, input bit good);
        end_t e;
        e.len = (n > MAX_LEN) ? MAX_LEN : n;
        e.err = er || (n < MIN_LEN) || (n > MAX_LEN);
        e.ok  = !e.err && good;
        return e;
    endfunction

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got[i] != exp_q[i]) return i;
        return -1;
    endfunction

    task automatic build(input int n);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(byte'($urandom));
        c = crc_of(n - 4);
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic expect_frame(input bit er);
        int m = (frm.size() > MAX_LEN) ? MAX_LEN : frm.size();
        for (int i = 0; i < m; i++) exp_q.push_back(frm[i]);
        exp_e.push_back(model_end(frm.size(), er, fcs_good()));
    endtask

    task automatic drive(input bit dv, input bit er, input logic [7:0] d);
        @(posedge iclk);
        #1;
        irx_dv = dv;
        irx_er = er;
        irx_d  = d;
    endtask

    task automatic send(input int npre, input int er_idx, input int ipg);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        foreach (frm[i]) drive(1'b1, i == er_idx, frm[i]);
        // rx_er and data while dv is low must be ignored
        for (int i = 0; i < ipg; i++) drive(1'b0, 1'($urandom), 8'($urandom));
    endtask

    task automatic settle();
        repeat (5) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear();
        got.delete();
        ends.delete();
        exp_q.delete();
        exp_e.delete();
    endtask

    task automatic check_run(input string name);
        int d = first_diff();
        vectors++;
        if (d != -1) begin
            miscompares++;
            $display("FAIL %s bytes: got %0d bytes (first diff %0d), want %0d bytes",
                     name, got.size(), d, exp_q.size());
        end
        vectors++;
        if (ends.size() != exp_e.size()) begin
            miscompares++;
            $display("FAIL %s end_count: got %0d, want %0d", name, ends.size(), exp_e.size());
        end else begin
            foreach (exp_e[i]) begin
                vectors++;
                if (ends[i].len !== exp_e[i].len || ends[i].ok !== exp_e[i].ok ||
                    ends[i].err !== exp_e[i].err) begin
                    miscompares++;
                    $display("FAIL %s status[%0d]: got len=%0d ok=%0b err=%0b, want len=%0d ok=%0b err=%0b",
                             name, i, ends[i].len, ends[i].ok, ends[i].err,
                             exp_e[i].len, exp_e[i].ok, exp_e[i].err);
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) drive(1'($urandom), 1'($urandom), 8'($urandom));
        vectors++;
        if ({odv, orx_d, oFSM_state, oframe_end, ocrc_ok, oerr, olen} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got odv=%b d=%h st=%b end=%b ok=%b err=%b len=%0d, want all 0",
                     odv, orx_d, oFSM_state, oframe_end, ocrc_ok, oerr, olen);
        end
        irx_dv = 1'b0;
        i_rst = 1'b1;
        settle();
    endtask

    task automatic test_good();
        for (int k = 0; k < 6; k++) begin
            clear();
            build(k == 0 ? 64 : 64 + $urandom_range(0, 150));
            expect_frame(1'b0);
            send((k == 0) ? 7 : $urandom_range(1, 7), -1, 1);
            settle();
            check_run("good");
        end
    endtask

    task automatic test_bad_crc();
        for (int k = 0; k < 3; k++) begin
            clear();
            build(64 + $urandom_range(0, 60));
            frm[k == 0 ? 20 : $urandom_range(0, 59)] ^= byte'(8'h01 << $urandom_range(0, 7));
            expect_frame(1'b0);
            send(7, -1, 1);
            settle();
            check_run("bad_crc");
        end
    endtask

    task automatic test_rx_er();
        clear();
        build(100);
        expect_frame(1'b1);
        send(7, 10, 1);
        settle();
        check_run("rx_er");
    endtask

    task automatic test_runt();
        clear();
        build(40);
        expect_frame(1'b0);
        send(7, -1, 1);
        settle();
        check_run("runt");
        clear();
        build(63);
        expect_frame(1'b0);
        send(3, -1, 1);
        settle();
        check_run("runt63");
    endtask

    task automatic test_length_bounds();
        clear();
        build(1600);
        expect_frame(1'b0);
        send(7, -1, 1);
        settle();
        check_run("overlong");
        clear();
        build(MAX_LEN);
        expect_frame(1'b0);
        send(7, -1, 1);
        settle();
        check_run("max_len");
    endtask

    task automatic test_back_to_back();
        clear();
        build(64);
        expect_frame(1'b0);
        send(7, -1, 1);
        build(64);
        expect_frame(1'b0);
        send(7, -1, 1);
        settle();
        check_run("back_to_back");
    endtask

    task automatic test_bad_preamble();
        clear();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hAA);
        drive(1'b1, 1'b0, 8'hD5);
        repeat (20) drive(1'b1, 1'b0, 8'($urandom));
        settle();
        check_run("bad_preamble");
        clear();
        drive(1'b1, 1'b0, 8'hD5);
        repeat (20) drive(1'b1, 1'b0, 8'($urandom));
        settle();
        check_run("no_preamble");
    endtask

    task automatic test_async_reset();
        clear();
        build(100);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, frm[i]);
        @(posedge iclk);
        #2;
        vectors++;
        if (odv !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_odv: got %b, want 1", odv);
        end
        i_rst = 1'b0;
        #1;
        vectors++;
        if ({odv, orx_d, oFSM_state, oframe_end, ocrc_ok, oerr, olen} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got odv=%b d=%h st=%b end=%b len=%0d, want all 0",
                     odv, orx_d, oFSM_state, oframe_end, olen);
        end
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        i_rst = 1'b1;
        clear();
        // dv is still high at release: this frame must be ignored entirely
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'($urandom));
        settle();
        check_run("reset_tail");
        clear();
        build(64);
        expect_frame(1'b0);
        send(7, -1, 1);
        settle();
        check_run("after_reset");
    endtask

    task automatic test_invariants();
        vectors++;
        if (overlap_seen) begin
            miscompares++;
            $display("FAIL end_with_odv: got overlap, want none");
        end
        vectors++;
        if (state_bad) begin
            miscompares++;
            $display("FAIL data_state_code: got code other than 011 with odv, want 011");
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_crc();
        test_rx_er();
        test_runt();
        test_length_bounds();
        test_back_to_back();
        test_bad_preamble();
        test_async_reset();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
